// File: rtl/kernel_launch_ctrl.sv
// Kernel launch controller: streams MEM_BYTES input bytes into kernel memory over a
// single-channel slave write port, pulses start, times the kernel run and reports.
`timescale 1ns/1ps
module kernel_launch_ctrl #(
    parameter int BASE_ADDR = 0,
    parameter int MEM_BYTES = 64,
    parameter int TIMEOUT   = 200000000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic         start_port,
    input  logic         done_port,
    output logic [1:0]   S_oe_ram,
    output logic [1:0]   S_we_ram,
    output logic [15:0]  S_addr_ram,
    output logic [127:0] S_Wdata_ram,
    output logic [13:0]  S_data_ram_size,
    input  logic [1:0]   Sout_DataRdy,
    output logic         res_valid,
    output logic         res_timeout,
    output logic [31:0]  res_cycles,
    output logic         busy
);
    localparam int               IDX_W     = (MEM_BYTES < 1) ? 1 : $clog2(MEM_BYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(MEM_BYTES - 1);
    localparam logic [7:0]       BASE8     = 8'(BASE_ADDR);
    localparam logic [31:0]      TIMEOUT32 = 32'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WRITE, S_START, S_RUN, S_REPORT
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_index;
    logic [31:0]      r_counter;
    logic             r_in_ready;
    logic             r_we;
    logic [7:0]       r_addr;
    logic [7:0]       r_wdata;
    logic             r_start;
    logic             r_res_valid;
    logic             r_res_timeout;
    logic [31:0]      r_res_cycles;
    logic             r_busy;
    logic             w_unused_rdy;

    // Only channel 0 of the slave port is used.
    assign w_unused_rdy = Sout_DataRdy[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_index       <= '0;
            r_counter     <= '0;
            r_in_ready    <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_start       <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_timeout <= 1'b0;
            r_res_cycles  <= '0;
            r_busy        <= 1'b0;
        end else begin
            // NOTE: pulses default low here with <= so any branch can raise them for one cycle.
            r_start     <= 1'b0;
            r_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b1;
                    if (MEM_BYTES == 0) begin
                        r_state <= S_START;
                        r_start <= 1'b1;
                    end else begin
                        r_state    <= S_LOAD;
                        r_in_ready <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        r_we       <= 1'b1;
                        r_addr     <= BASE8 + 8'(r_index);
                        r_wdata    <= in_data;
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // Address/data stay frozen until the slave acknowledges.
                    if (Sout_DataRdy[0]) begin
                        r_we    <= 1'b0;
                        r_addr  <= '0;
                        r_wdata <= '0;
                        r_index <= r_index + IDX_W'(1);
                        if (r_index == LAST_IDX) begin
                            r_state <= S_START;
                            r_start <= 1'b1;
                        end else begin
                            r_state    <= S_LOAD;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    r_counter <= 32'd1;
                    r_state   <= S_RUN;
                end
                S_RUN: begin
                    if (done_port) begin
                        r_res_cycles  <= r_counter;
                        r_res_timeout <= 1'b0;
                        r_res_valid   <= 1'b1;
                        r_state       <= S_REPORT;
                    end else if (r_counter >= TIMEOUT32) begin
                        r_res_cycles  <= TIMEOUT32;
                        r_res_timeout <= 1'b1;
                        r_res_valid   <= 1'b1;
                        r_state       <= S_REPORT;
                    end else begin
                        r_counter <= r_counter + 32'd1;
                    end
                end
                S_REPORT: begin
                    r_busy    <= 1'b0;
                    r_index   <= '0;
                    r_counter <= '0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready        = r_in_ready;
    assign start_port      = r_start;
    assign S_oe_ram        = 2'b00;
    assign S_we_ram        = {1'b0, r_we};
    assign S_addr_ram      = {8'h00, r_addr};
    assign S_Wdata_ram     = {120'd0, r_wdata};
    assign S_data_ram_size = {7'd0, 3'd0, r_we, 3'd0};
    assign res_valid       = r_res_valid;
    assign res_timeout     = r_res_timeout;
    assign res_cycles      = r_res_cycles;
    assign busy            = r_busy;

endmodule

// File: tb/tb_kernel_launch_ctrl.sv
// Scoreboard bench: randomized byte feed, slave acks and kernel runs; expected writes and
// results are queued when stimulus is issued and popped by an independent monitor.
`timescale 1ns/1ps
module tb_kernel_launch_ctrl;
    localparam int A_BASE = 'hFE;
    localparam int A_MEM  = 4;
    localparam int A_TO   = 20;
    localparam int B_TO   = 8;

    typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { logic [31:0] cycles; logic to; } res_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         a_in_valid, a_in_ready, a_start, a_done;
    logic [7:0]   a_in_data;
    logic [1:0]   a_oe, a_we, a_rdy;
    logic [15:0]  a_addr;
    logic [127:0] a_wdata;
    logic [13:0]  a_size;
    logic         a_res_valid, a_res_to, a_busy;
    logic [31:0]  a_res_cycles;

    logic         b_in_ready, b_start;
    logic [1:0]   b_oe, b_we;
    logic [15:0]  b_addr;
    logic [127:0] b_wdata;
    logic [13:0]  b_size;
    logic         b_res_valid, b_res_to, b_busy;
    logic [31:0]  b_res_cycles;

    kernel_launch_ctrl #(.BASE_ADDR(A_BASE), .MEM_BYTES(A_MEM), .TIMEOUT(A_TO)) u_dut_a (
        .clock(clk), .reset(rst_n),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .start_port(a_start), .done_port(a_done),
        .S_oe_ram(a_oe), .S_we_ram(a_we), .S_addr_ram(a_addr), .S_Wdata_ram(a_wdata),
        .S_data_ram_size(a_size), .Sout_DataRdy(a_rdy),
        .res_valid(a_res_valid), .res_timeout(a_res_to), .res_cycles(a_res_cycles),
        .busy(a_busy)
    );

    kernel_launch_ctrl #(.BASE_ADDR(0), .MEM_BYTES(0), .TIMEOUT(B_TO)) u_dut_b (
        .clock(clk), .reset(rst_n),
        .in_valid(1'b1), .in_data(8'h5A), .in_ready(b_in_ready),
        .start_port(b_start), .done_port(1'b0),
        .S_oe_ram(b_oe), .S_we_ram(b_we), .S_addr_ram(b_addr), .S_Wdata_ram(b_wdata),
        .S_data_ram_size(b_size), .Sout_DataRdy(2'b11),
        .res_valid(b_res_valid), .res_timeout(b_res_to), .res_cycles(b_res_cycles),
        .busy(b_busy)
    );

    wr_t  wr_q[$];
    int   hold_q[$];
    res_t res_q[$];

    int   n_checks = 0;
    int   n_err = 0;
    int   byte_total = 0;
    int   writes_in_run = 0;
    int   we_cycles = 0;
    int   runs_done = 0;
    int   starts_seen = 0;
    int   run_k = -1;
    int   run_n = 0;
    logic prev_start = 1'b0;
    logic expect_idle = 1'b0;
    logic long_run = 1'b0;
    logic took = 1'b0;
    logic [7:0] held_addr, held_data;
    int   ack_tbl[4] = '{0, 3, 0, 0};
    int   run_tbl[4] = '{7, 1, 20, 21};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 32'({a_in_ready, a_start, a_we, a_oe, a_res_valid, a_res_to, a_busy}), 0);
        check({tag, "_bus"}, 32'(|{a_addr, a_wdata, a_size}), 0);
        check({tag, "_cycles"}, a_res_cycles, 0);
        check({tag, "_b"}, 32'({b_start, b_busy, b_res_valid, b_res_to, |b_res_cycles}), 0);
    endtask

    task automatic wait_runs(input int target);
        int i;
        i = 0;
        while (runs_done < target && i < 5000) begin
            @(posedge clk);
            i++;
        end
        check("runs_completed", 32'(runs_done >= target), 1);
    endtask

    // Byte source: the k-th byte accepted since reset lands at BASE + (k mod MEM_BYTES).
    initial begin : feeder
        a_in_valid = 1'b0;
        a_in_data  = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (took) begin
                a_in_valid = 1'b0;
                took = 1'b0;
            end
            if (!a_in_valid && $urandom_range(0, 3) != 0) begin
                a_in_valid = 1'b1;
                a_in_data  = 8'($urandom);
            end
            @(negedge clk);
            if (rst_n && a_in_valid && a_in_ready) begin
                wr_t w;
                w.addr = 8'(A_BASE + (byte_total % A_MEM));
                w.data = a_in_data;
                wr_q.push_back(w);
                byte_total++;
                took = 1'b1;
            end
        end
    end

    // Slave: acknowledges each write after d extra cycles, with stray acks elsewhere.
    initial begin : slave
        int d, cnt, nwr;
        logic in_wr;
        a_rdy = 2'b00;
        d = 0; cnt = 0; nwr = 0; in_wr = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (a_we[0]) begin
                if (!in_wr) begin
                    if (nwr < 4) d = ack_tbl[nwr];
                    else d = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
                    nwr++;
                    cnt = 0;
                    in_wr = 1'b1;
                    hold_q.push_back(d);
                end else begin
                    cnt++;
                end
                a_rdy[0] = (cnt >= d);
            end else begin
                in_wr = 1'b0;
                a_rdy[0] = ($urandom_range(0, 2) == 0);
            end
            a_rdy[1] = 1'($urandom);
        end
    end

    // Kernel: raises done in cycle N after start, or never when N exceeds TIMEOUT.
    initial begin : kernel
        res_t r;
        a_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (run_k >= 0) begin
                run_k++;
                if (run_k > run_n || run_k > A_TO) begin
                    run_k = -1;
                    a_done = 1'b0;
                end else begin
                    a_done = (run_k == run_n);
                end
            end else begin
                a_done = ($urandom_range(0, 3) == 0);
            end
            @(negedge clk);
            if (rst_n && a_start) begin
                if (long_run) run_n = A_TO + 4;
                else if (starts_seen < 4) run_n = run_tbl[starts_seen];
                else run_n = $urandom_range(1, A_TO + 4);
                starts_seen++;
                if (run_n <= A_TO) begin
                    r.cycles = 32'(run_n);
                    r.to = 1'b0;
                end else begin
                    r.cycles = 32'(A_TO);
                    r.to = 1'b1;
                end
                res_q.push_back(r);
                run_k = 0;
            end
        end
    end

    initial begin : monitor
        wr_t  w;
        res_t r;
        int   d;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            check("const_zero", 32'(a_oe != 0 || a_we[1] || a_addr[15:8] != 0 ||
                                    a_wdata[127:8] != '0 || a_size[13:7] != 0), 0);
            if (expect_idle) begin
                check("idle_after_report", 32'({a_busy, a_res_valid}), 0);
                expect_idle = 1'b0;
            end
            if (a_we[0]) begin
                check("in_ready_in_write", 32'(a_in_ready), 0);
                we_cycles++;
                if (we_cycles == 1) begin
                    held_addr = a_addr[7:0];
                    held_data = a_wdata[7:0];
                end else begin
                    check("write_hold", {a_addr[7:0], a_wdata[7:0]}, {held_addr, held_data});
                end
                if (a_rdy[0]) begin
                    check("write_expected", 32'(wr_q.size() > 0 && hold_q.size() > 0), 1);
                    if (wr_q.size() > 0 && hold_q.size() > 0) begin
                        w = wr_q.pop_front();
                        d = hold_q.pop_front();
                        check("write_addr", 32'(a_addr[7:0]), 32'(w.addr));
                        check("write_data", 32'(a_wdata[7:0]), 32'(w.data));
                        check("write_size", 32'(a_size), 8);
                        check("write_hold_cycles", we_cycles, d + 1);
                    end
                    writes_in_run++;
                    we_cycles = 0;
                end
            end else begin
                check("size_outside_write", 32'(a_size), 0);
                we_cycles = 0;
            end
            if (a_start) begin
                check("start_one_cycle", 32'(prev_start), 0);
                check("writes_before_start", writes_in_run, A_MEM);
                check("busy_at_start", 32'(a_busy), 1);
                writes_in_run = 0;
            end
            prev_start = a_start;
            if (a_res_valid) begin
                check("result_expected", 32'(res_q.size() > 0), 1);
                if (res_q.size() > 0) begin
                    r = res_q.pop_front();
                    check("res_cycles", a_res_cycles, r.cycles);
                    check("res_timeout", 32'(a_res_to), 32'(r.to));
                end
                runs_done++;
                expect_idle = 1'b1;
            end
        end
    end

    // Zero-byte instance: never loads, and every run times out after B_TO cycles.
    always @(negedge clk) begin
        if (rst_n) begin
            check("b_no_load", 32'({b_in_ready, b_we}), 0);
            check("b_bus_idle", 32'(|{b_oe, b_addr, b_wdata, b_size}), 0);
            if (b_res_valid) begin
                check("b_res_cycles", b_res_cycles, B_TO);
                check("b_res_timeout", 32'(b_res_to), 1);
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic saw;
        int   target;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_initial");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("b_start_second_cycle", 32'(b_start), 1);
        check("a_load_after_idle", 32'(a_in_ready), 1);

        wait_runs(12);

        // Abort a run at counter 5 with reset; nothing from it may surface later.
        long_run = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 3000 && !saw; i++) begin
            @(negedge clk);
            saw = a_start;
        end
        check("long_run_started", 32'(saw), 1);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        wr_q.delete();
        hold_q.delete();
        res_q.delete();
        byte_total    = 0;
        writes_in_run = 0;
        we_cycles     = 0;
        run_k         = -1;
        prev_start    = 1'b0;
        expect_idle   = 1'b0;
        long_run      = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_in_run");
        @(negedge clk);
        rst_n = 1'b1;

        target = runs_done + 8;
        wait_runs(target);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/kernel_launch_ctrl.md
KERNEL_LAUNCH_CTRL -- requirements
Module: kernel_launch_ctrl

Interface
REQ-001 Parameter: BASE_ADDR, 0, slave byte address of first loaded byte.
REQ-002 Parameter: MEM_BYTES, 64, bytes loaded into kernel memory per run (0 allowed).
REQ-003 Parameter: TIMEOUT, 200000000, maximum run cycles before abort.
REQ-004 clock  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low.
REQ-006 in_valid  in  1  input byte stream valid.
REQ-007 in_data  in  8  input byte.
REQ-008 in_ready  out  1  block accepts in_data this cycle.
REQ-009 start_port  out  1  kernel start pulse.
REQ-010 done_port  in  1  kernel completion.
REQ-011 S_oe_ram  out  2  slave read enables; constant 0.
REQ-012 S_we_ram  out  2  slave write enables; bit 0 used, bit 1 constant 0.
REQ-013 S_addr_ram  out  16  slave addresses; [7:0] channel 0, [15:8] constant 0.
REQ-014 S_Wdata_ram  out  128  write data; [7:0] loaded byte, all other bits 0.
REQ-015 S_data_ram_size  out  14  access size; [6:0]=8 during writes, else 0; [13:7] constant 0.
REQ-016 Sout_DataRdy  in  2  slave acknowledge; bit 0 used.
REQ-017 res_valid  out  1  one-cycle result strobe.
REQ-018 res_timeout  out  1  run aborted by TIMEOUT; valid with res_valid.
REQ-019 res_cycles  out  32  start-to-done cycle count; valid with res_valid.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 States: IDLE, LOAD, WRITE, START, RUN, REPORT.
REQ-022 IDLE: go to LOAD next cycle; if MEM_BYTES=0, go to START.
REQ-023 LOAD: in_ready=1; on in_valid&in_ready, latch byte and address BASE_ADDR+index, go WRITE.
REQ-024 WRITE: in_ready=0; drive S_we_ram[0]=1, address, data, size=8; hold all stable until Sout_DataRdy[0]=1.
REQ-025 WRITE ack cycle: index+1; if index reaches MEM_BYTES go START, else go LOAD.
REQ-026 Ack in the first WRITE cycle is legal: minimum 2 cycles per byte (LOAD, WRITE).
REQ-027 Address arithmetic is 8-bit modulo; BASE_ADDR+MEM_BYTES>256 wraps to 0.
REQ-028 START: start_port=1 for exactly one cycle; counter set to 1; go RUN.
REQ-029 RUN: sample done_port each cycle; if high, res_cycles:=counter, res_timeout:=0, go REPORT.
REQ-030 RUN: if done_port low and counter=TIMEOUT, res_cycles:=TIMEOUT, res_timeout:=1, go REPORT; otherwise counter+1.
REQ-031 done_port in any state other than RUN is ignored.
REQ-032 Cycle count: start_port in cycle 0, done_port first high in cycle N gives res_cycles=N.
REQ-033 REPORT: res_valid=1 one cycle; res_cycles/res_timeout hold until next REPORT; go IDLE; index cleared.
REQ-034 in_valid outside LOAD is not consumed; in_ready=0 everywhere except LOAD.
REQ-035 Sout_DataRdy[0] outside WRITE is ignored.

Reset
REQ-036 reset low, at any time including mid-write or mid-run: state IDLE, index 0, counter 0, all outputs 0 (res_cycles 0, res_timeout 0).
REQ-037 In-flight write is dropped on reset; after release, loading restarts at BASE_ADDR.

Verification
REQ-038 MEM_BYTES=4, BASE_ADDR=0x10, bytes 0xA1..0xA4, DataRdy same cycle -> four writes to 0x10..0x13 on consecutive even cycles, size 8; then one start_port pulse.
REQ-039 DataRdy delayed 3 cycles on byte 2 -> we/addr/data held 4 cycles; in_ready low throughout; no byte lost or duplicated.
REQ-040 done_port high 7 cycles after start_port -> res_valid one cycle, res_cycles=7, res_timeout=0, busy low next cycle.
REQ-041 TIMEOUT=20, done_port never asserted -> res_valid with res_cycles=20, res_timeout=1.
REQ-042 reset low during RUN at counter 5, then released -> all outputs 0, next run reloads from BASE_ADDR, no stale res_valid.
REQ-043 MEM_BYTES=0 -> no writes, start_port in second cycle after reset release; BASE_ADDR=0xFE, MEM_BYTES=4 -> addresses 0xFE,0xFF,0x00,0x01.
